// File: rtl/arbiter_rr_burst_if.sv
// Bus bundle between the requesting agents and arbiter_rr_burst.
// Defining ARB_WEIGHT_EN adds the per-agent weight vector to the bundle.
interface arbiter_rr_burst_if #(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
);
   localparam int TW = $clog2(N);
   localparam int BW = $clog2(MAX_BURST + 1);

   logic [N-1:0]  pndng;
   logic [N-1:0]  blk;
   logic          xfer;
   logic [TW-1:0] trn;
   logic          trn_vld;
   logic [BW-1:0] burst;

`ifdef ARB_WEIGHT_EN
   logic [N*BW-1:0] weight;

   modport master (
      output pndng, blk, xfer, weight,
      input  trn, trn_vld, burst
   );

   modport slave (
      input  pndng, blk, xfer, weight,
      output trn, trn_vld, burst
   );
`else
   modport master (
      output pndng, blk, xfer,
      input  trn, trn_vld, burst
   );

   modport slave (
      input  pndng, blk, xfer,
      output trn, trn_vld, burst
   );
`endif
endinterface

// File: rtl/arbiter_rr_burst.sv
// Round-robin bus arbiter granting one agent for up to a per-agent number of transfers.
// Defining ARB_WEIGHT_EN takes the per-agent limit from the weight vector instead of MAX_BURST.
module arbiter_rr_burst #(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input logic               clk,
   input logic               rst,
   arbiter_rr_burst_if.slave bus
);
   localparam int TW = $clog2(N);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state_r;
   logic [TW-1:0] trn_r;
   logic          trn_vld_r;
   logic [BW-1:0] burst_r;
   logic [TW-1:0] ptr_r;

   state_t        state_nxt_s;
   logic [TW-1:0] trn_nxt_s;
   logic          trn_vld_nxt_s;
   logic [BW-1:0] burst_nxt_s;
   logic [TW-1:0] ptr_nxt_s;

   logic [N-1:0]  elig_s;
   logic [TW-1:0] pick_s;
   logic [BW-1:0] limit_s [N];
   logic [BW-1:0] cur_limit_s;
   logic          counted_s;
   logic          expire_s;
   logic          grant_end_s;

   // First eligible agent after p, wrapping, with p itself considered last.
   function automatic logic [TW-1:0] rr_pick(input logic [N-1:0] e, input logic [TW-1:0] p);
      logic [TW-1:0] sel;
      logic          found;
      sel   = p;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (int'(p) + k) % N;
         if (!found && e[j]) begin
            sel   = TW'(j);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

`ifdef ARB_WEIGHT_EN
   // Zero weight still allows one transfer; oversize weights saturate.
   function automatic logic [BW-1:0] clamp_limit(input logic [BW-1:0] w);
      logic [BW-1:0] lim;
      if (w == {BW{1'b0}}) begin
         lim = BW'(1);
      end else if (w > BW'(MAX_BURST)) begin
         lim = BW'(MAX_BURST);
      end else begin
         lim = w;
      end
      return lim;
   endfunction
`endif

   // Per-agent burst limits.
   always_comb begin
      for (int i = 0; i < N; i++) begin
`ifdef ARB_WEIGHT_EN
         limit_s[i] = clamp_limit(bus.weight[i*BW +: BW]);
`else
         limit_s[i] = BW'(MAX_BURST);
`endif
      end
   end

   // Eligibility, candidate selection and end-of-grant detection.
   always_comb begin
      elig_s      = bus.pndng & ~bus.blk;
      pick_s      = rr_pick(elig_s, ptr_r);
      cur_limit_s = limit_s[trn_r];
      counted_s   = bus.xfer & bus.pndng[trn_r];
      expire_s    = counted_s && ((burst_r + BW'(1)) == cur_limit_s);
      grant_end_s = expire_s | ~bus.pndng[trn_r] | bus.blk[trn_r];
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt_s   = state_r;
      trn_nxt_s     = trn_r;
      trn_vld_nxt_s = trn_vld_r;
      burst_nxt_s   = burst_r;
      ptr_nxt_s     = ptr_r;
      case (state_r)
         IDLE: begin
            if (elig_s != {N{1'b0}}) begin
               state_nxt_s   = GRANT;
               trn_nxt_s     = pick_s;
               ptr_nxt_s     = pick_s;
               trn_vld_nxt_s = 1'b1;
               burst_nxt_s   = {BW{1'b0}};
            end else begin
               trn_vld_nxt_s = 1'b0;
               burst_nxt_s   = {BW{1'b0}};
            end
         end
         GRANT: begin
            if (grant_end_s) begin
               // Hand over in the same cycle so back-to-back grants have no bubble.
               burst_nxt_s = {BW{1'b0}};
               if (elig_s != {N{1'b0}}) begin
                  state_nxt_s   = GRANT;
                  trn_nxt_s     = pick_s;
                  ptr_nxt_s     = pick_s;
                  trn_vld_nxt_s = 1'b1;
               end else begin
                  state_nxt_s   = IDLE;
                  trn_vld_nxt_s = 1'b0;
               end
            end else begin
               if (counted_s) begin
                  burst_nxt_s = burst_r + BW'(1);
               end else begin
                  burst_nxt_s = burst_r;
               end
            end
         end
         default: begin
            state_nxt_s   = IDLE;
            trn_vld_nxt_s = 1'b0;
            burst_nxt_s   = {BW{1'b0}};
         end
      endcase
   end

   // State and output registers; reset leaves agent 0 with first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         trn_r     <= {TW{1'b0}};
         trn_vld_r <= 1'b0;
         burst_r   <= {BW{1'b0}};
         ptr_r     <= TW'(N - 1);
      end else begin
         state_r   <= state_nxt_s;
         trn_r     <= trn_nxt_s;
         trn_vld_r <= trn_vld_nxt_s;
         burst_r   <= burst_nxt_s;
         ptr_r     <= ptr_nxt_s;
      end
   end

   assign bus.trn     = trn_r;
   assign bus.trn_vld = trn_vld_r;
   assign bus.burst   = burst_r;

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Randomised and directed bench for arbiter_rr_burst against a cycle-level reference model.
module tb_arbiter_rr_burst;
   localparam int N  = 4;
   localparam int MB = 4;
   localparam int TW = $clog2(N);
   localparam int BW = $clog2(MB + 1);

   logic clk;
   logic rst;

   arbiter_rr_burst_if #(.N(N), .MAX_BURST(MB)) bus ();

   arbiter_rr_burst #(.N(N), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int fails;

   int m_vld;
   int m_trn;
   int m_burst;
   int m_ptr;

   task automatic cmp(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int lim(input int i);
`ifdef ARB_WEIGHT_EN
      int w;
      w = int'(bus.weight[i*BW +: BW]);
      if (w == 0) return 1;
      if (w > MB) return MB;
      return w;
`else
      return MB;
`endif
   endfunction

   function automatic int pick(input logic [N-1:0] e, input int p);
      for (int k = 1; k <= N; k++) begin
         if (e[(p + k) % N]) return (p + k) % N;
      end
      return p;
   endfunction

   task automatic model_reset();
      m_vld   = 0;
      m_trn   = 0;
      m_burst = 0;
      m_ptr   = N - 1;
   endtask

   task automatic model_step();
      logic [N-1:0] e;
      int cnt;
      int nb;
      bit done;
      if (rst) begin
         model_reset();
         return;
      end
      e = bus.pndng & ~bus.blk;
      if (m_vld == 0) begin
         if (e != '0) begin
            m_trn   = pick(e, m_ptr);
            m_ptr   = m_trn;
            m_vld   = 1;
            m_burst = 0;
         end
      end else begin
         cnt  = (bus.xfer && bus.pndng[m_trn]) ? 1 : 0;
         nb   = m_burst + cnt;
         done = (cnt == 1 && nb == lim(m_trn)) || !bus.pndng[m_trn] || bus.blk[m_trn];
         if (done) begin
            m_burst = 0;
            if (e != '0) begin
               m_trn = pick(e, m_trn);
               m_ptr = m_trn;
            end else begin
               m_vld = 0;
            end
         end else begin
            m_burst = nb;
         end
      end
   endtask

   task automatic compare_all();
      cmp("trn_vld", int'(bus.trn_vld), m_vld);
      cmp("trn", int'(bus.trn), m_trn);
      cmp("burst", int'(bus.burst), m_burst);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic lit(input string nm, input int t, input int v, input int b);
      cmp({nm, "_trn"}, int'(bus.trn), t);
      cmp({nm, "_vld"}, int'(bus.trn_vld), v);
      cmp({nm, "_burst"}, int'(bus.burst), b);
   endtask

   // Asynchronous reset pulse starting between clock edges.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1 lit("async_rst", 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare_all();
   endtask

   task automatic set_all_weights(input int w);
`ifdef ARB_WEIGHT_EN
      for (int i = 0; i < N; i++) bus.weight[i*BW +: BW] = BW'(w);
`endif
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      bus.pndng = '0;
      bus.blk   = '0;
      bus.xfer  = 1'b0;
      set_all_weights(MB);
      model_reset();
      repeat (2) @(negedge clk);
      lit("reset", 0, 0, 0);
      rst = 1'b0;

      // Full rotation with all agents pending and continuous transfers.
      bus.pndng = 4'b1111;
      bus.xfer  = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         tick();
         lit("rotate", ((c - 1) / 4) % 4, 1, (c - 1) % 4);
      end

      // Single request, drop after two transfers.
      pulse_reset();
      bus.pndng = 4'b0100;
      bus.xfer  = 1'b0;
      tick();
      lit("single_grant", 2, 1, 0);
      bus.xfer = 1'b1;
      tick();
      tick();
      lit("single_two", 2, 1, 2);
      bus.pndng = 4'b0000;
      bus.xfer  = 1'b0;
      tick();
      lit("single_drop", 2, 0, 0);

      // Blocked grant hands over to the next eligible agent.
      pulse_reset();
      bus.pndng = 4'b0010;
      tick();
      lit("blk_first", 1, 1, 0);
      bus.xfer = 1'b1;
      tick();
      lit("blk_one", 1, 1, 1);
      bus.blk   = 4'b0010;
      bus.pndng = 4'b1010;
      bus.xfer  = 1'b0;
      tick();
      lit("blk_handover", 3, 1, 0);
      bus.blk  = 4'b0000;
      bus.xfer = 1'b1;
      repeat (3) tick();
      lit("blk_agent3", 3, 1, 3);
      tick();
      lit("blk_back1", 1, 1, 0);

      // Sole agent re-granted with burst wrapping.
      pulse_reset();
      bus.pndng = 4'b0001;
      bus.xfer  = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         lit("sole", 0, 1, (c - 1) % 4);
      end

      // Reset in mid-grant, then first grant goes to agent 0.
      pulse_reset();
      bus.pndng = 4'b0100;
      bus.xfer  = 1'b0;
      tick();
      bus.xfer = 1'b1;
      repeat (3) tick();
      lit("pre_rst", 2, 1, 3);
      pulse_reset();
      bus.pndng = 4'b1111;
      bus.xfer  = 1'b0;
      tick();
      lit("post_rst", 0, 1, 0);

`ifdef ARB_WEIGHT_EN
      // Weighted burst lengths 1,2,1,3 for agents 0..3.
      begin
         int exp_t [9] = '{0, 1, 1, 2, 3, 3, 3, 0, 1};
         int exp_b [9] = '{0, 0, 1, 0, 0, 1, 2, 0, 0};
         pulse_reset();
         bus.weight = {3'd3, 3'd0, 3'd2, 3'd1};
         bus.pndng  = 4'b1111;
         bus.xfer   = 1'b1;
         for (int c = 0; c < 9; c++) begin
            tick();
            lit("weight", exp_t[c], 1, exp_b[c]);
         end
      end
`endif

      // Randomised traffic checked against the model every cycle.
      pulse_reset();
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) bus.pndng[i] = ~bus.pndng[i];
            bus.blk[i] = ($urandom_range(0, 7) == 0);
         end
         bus.xfer = ($urandom_range(0, 3) != 0);
`ifdef ARB_WEIGHT_EN
         if ($urandom_range(0, 15) == 0) begin
            for (int i = 0; i < N; i++) bus.weight[i*BW +: BW] = BW'($urandom_range(0, 7));
         end
`endif
         if ($urandom_range(0, 499) == 0) pulse_reset();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
